// File: rtl/jtkicker_romslot_if.sv
// ROM request / SDRAM fetch bus of the single-word ROM slot cache.
// The slave modport is the slot's view; the master modport is its environment.
interface jtkicker_romslot_if #(
    parameter int AW = 13
);
    logic          rom_cs;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic          rom_ok;
    logic          inval;
    logic [21:0]   sdram_addr;
    logic          sdram_req;
    logic          sdram_ack;
    logic          sdram_dst;
    logic [15:0]   sdram_din;

    modport slave (
        input  rom_cs, rom_addr, inval, sdram_ack, sdram_dst, sdram_din,
        output rom_data, rom_ok, sdram_addr, sdram_req
    );

    modport master (
        output rom_cs, rom_addr, inval, sdram_ack, sdram_dst, sdram_din,
        input  rom_data, rom_ok, sdram_addr, sdram_req
    );
endinterface

// File: rtl/jtkicker_romslot.sv
// One-word ROM cache in front of the SDRAM: zero-latency hits, miss fetch via req/ack/dst.
//   state | meaning
//   IDLE  | serving hits, waiting for a cs miss
//   REQ   | sdram_req high, waiting for ack
//   WAIT  | request accepted, waiting for the data strobe
module jtkicker_romslot #(
    parameter int          AW     = 13,
    parameter logic [21:0] OFFSET = 22'd0
) (
    input logic               clk,
    input logic               rst_n,
    jtkicker_romslot_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [15:0]   r_data;
    logic [AW-2:0] r_tag;
    logic [AW-2:0] r_tag_pend;
    logic          r_valid;
    logic [21:0]   r_sdram_addr;
    logic [AW-2:0] w_word;
    logic          w_hit;
    logic          w_start;
    logic          w_fill;

    assign w_word = bus.rom_addr[AW-1:1];
    assign w_hit  = r_valid && (r_tag == w_word);

    // inval gates rom_ok directly so the first inval cycle cannot report a stale hit
    assign bus.rom_ok     = bus.rom_cs && w_hit && !bus.inval;
    assign bus.rom_data   = bus.rom_addr[0] ? r_data[15:8] : r_data[7:0];
    assign bus.sdram_req  = (r_state == ST_REQ);
    assign bus.sdram_addr = r_sdram_addr;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_fill      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.rom_cs && !w_hit && !bus.inval) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.sdram_ack) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.sdram_dst) begin
                    w_fill      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sdram_addr <= OFFSET;
            r_tag_pend   <= '0;
            r_data       <= '0;
            r_tag        <= '0;
            r_valid      <= 1'b0;
        end else begin
            if (w_start) begin
                r_sdram_addr <= OFFSET + 22'(w_word);
                r_tag_pend   <= w_word;
            end
            // data and tag still load under inval; only the valid bit is suppressed
            if (w_fill) begin
                r_data <= bus.sdram_din;
                r_tag  <= r_tag_pend;
            end
            if (bus.inval)   r_valid <= 1'b0;
            else if (w_fill) r_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_jtkicker_romslot.sv
// Directed scenarios plus random traffic against a word-level cache model of jtkicker_romslot.
module tb_jtkicker_romslot;
    localparam int          AW   = 13;
    localparam logic [21:0] OFFS = 22'h100;

    logic clk;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    jtkicker_romslot_if #(.AW(AW)) bus ();

    jtkicker_romslot #(.AW(AW), .OFFSET(OFFS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rom(input logic cs, input logic [AW-1:0] a);
        bus.rom_cs   = cs;
        bus.rom_addr = a;
        #1;
    endtask

    // Play the SDRAM controller for one fetch of the word holding byte address a.
    task automatic serve(input logic [AW-1:0] a, input logic [15:0] din);
        int k = 0;
        while (bus.sdram_req !== 1'b1 && k < 10) begin
            step();
            k++;
        end
        chk("req_seen", 32'(bus.sdram_req), 32'd1);
        chk("fetch_addr", 32'(bus.sdram_addr), 32'(OFFS + 22'(a >> 1)));
        repeat ($urandom_range(0, 2)) begin
            step();
            chk("req_hold", 32'(bus.sdram_req), 32'd1);
        end
        bus.sdram_ack = 1'b1;
        step();
        bus.sdram_ack = 1'b0;
        chk("req_drop", 32'(bus.sdram_req), 32'd0);
        repeat ($urandom_range(0, 3)) begin
            step();
            chk("no_early_ok", 32'(bus.rom_ok), 32'd0);
        end
        bus.sdram_din = din;
        bus.sdram_dst = 1'b1;
        step();
        bus.sdram_dst = 1'b0;
    endtask

    function automatic logic [7:0] pick(input logic [15:0] w, input logic [AW-1:0] a);
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    logic          m_valid;
    logic [AW-2:0] m_tag;
    logic [15:0]   m_data;

    initial begin
        logic [AW-1:0] a;
        logic [15:0]   din;
        logic          exp_hit;
        int            r;

        rst_n = 1'b0;
        bus.rom_cs = 1'b0; bus.rom_addr = '0; bus.inval = 1'b0;
        bus.sdram_ack = 1'b0; bus.sdram_dst = 1'b0; bus.sdram_din = '0;
        step(); step();
        chk("rst_ok", 32'(bus.rom_ok), 32'd0);
        chk("rst_data", 32'(bus.rom_data), 32'd0);
        chk("rst_req", 32'(bus.sdram_req), 32'd0);
        chk("rst_addr", 32'(bus.sdram_addr), 32'(OFFS));
        rst_n = 1'b1;

        // cold miss
        set_rom(1'b1, 13'h0005);
        chk("cold_ok0", 32'(bus.rom_ok), 32'd0);
        step();
        chk("cold_req", 32'(bus.sdram_req), 32'd1);
        chk("cold_addr", 32'(bus.sdram_addr), 32'h102);
        step();
        chk("cold_req2", 32'(bus.sdram_req), 32'd1);
        bus.sdram_ack = 1'b1;
        step();
        bus.sdram_ack = 1'b0;
        chk("cold_wait", 32'(bus.sdram_req), 32'd0);
        step(); step();
        bus.sdram_din = 16'hBEEF; bus.sdram_dst = 1'b1;
        #1;
        chk("cold_pend_nook", 32'(bus.rom_ok), 32'd0);
        step();
        bus.sdram_dst = 1'b0;
        chk("cold_ok", 32'(bus.rom_ok), 32'd1);
        chk("cold_data", 32'(bus.rom_data), 32'hBE);

        // hit on the other byte of the same word
        set_rom(1'b1, 13'h0004);
        chk("hit_ok", 32'(bus.rom_ok), 32'd1);
        chk("hit_data", 32'(bus.rom_data), 32'hEF);
        step();
        chk("hit_noreq", 32'(bus.sdram_req), 32'd0);

        // address change mid-fetch
        set_rom(1'b1, 13'h0010);
        step();
        chk("mid_addr", 32'(bus.sdram_addr), 32'h108);
        bus.sdram_ack = 1'b1;
        step();
        bus.sdram_ack = 1'b0;
        set_rom(1'b1, 13'h0020);
        bus.sdram_din = 16'h1234; bus.sdram_dst = 1'b1;
        step();
        bus.sdram_dst = 1'b0;
        chk("mid_ok0", 32'(bus.rom_ok), 32'd0);
        chk("mid_idle", 32'(bus.sdram_req), 32'd0);
        step();
        chk("mid_req2", 32'(bus.sdram_req), 32'd1);
        chk("mid_addr2", 32'(bus.sdram_addr), 32'h110);
        set_rom(1'b1, 13'h0011);
        chk("mid_tag8_ok", 32'(bus.rom_ok), 32'd1);
        chk("mid_tag8_data", 32'(bus.rom_data), 32'h12);
        set_rom(1'b1, 13'h0020);
        serve(13'h0020, 16'h5678);
        chk("mid_fill_ok", 32'(bus.rom_ok), 32'd1);
        chk("mid_fill_data", 32'(bus.rom_data), 32'h78);

        // inval coincident with dst
        set_rom(1'b1, 13'h0030);
        step();
        chk("inv_addr", 32'(bus.sdram_addr), 32'h118);
        bus.sdram_ack = 1'b1;
        step();
        bus.sdram_ack = 1'b0;
        bus.sdram_din = 16'hAAAA; bus.sdram_dst = 1'b1; bus.inval = 1'b1;
        #1;
        chk("inv_ok_pre", 32'(bus.rom_ok), 32'd0);
        step();
        bus.sdram_dst = 1'b0;
        chk("inv_ok", 32'(bus.rom_ok), 32'd0);
        chk("inv_data_loaded", 32'(bus.rom_data), 32'hAA);
        step();
        chk("inv_nofetch", 32'(bus.sdram_req), 32'd0);
        bus.inval = 1'b0;
        #1;
        chk("inv_still_invalid", 32'(bus.rom_ok), 32'd0);
        step();
        chk("inv_refetch", 32'(bus.sdram_req), 32'd1);
        chk("inv_refetch_addr", 32'(bus.sdram_addr), 32'h118);
        serve(13'h0030, 16'hBBBB);
        chk("inv_fill_ok", 32'(bus.rom_ok), 32'd1);
        chk("inv_fill_data", 32'(bus.rom_data), 32'hBB);

        // reset during WAIT
        set_rom(1'b1, 13'h0040);
        step();
        bus.sdram_ack = 1'b1;
        step();
        bus.sdram_ack = 1'b0;
        bus.rom_cs = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(bus.sdram_req), 32'd0);
        chk("arst_addr", 32'(bus.sdram_addr), 32'(OFFS));
        chk("arst_data", 32'(bus.rom_data), 32'd0);
        step();
        rst_n = 1'b1;
        bus.sdram_din = 16'hCCCC; bus.sdram_dst = 1'b1;
        step();
        bus.sdram_dst = 1'b0;
        set_rom(1'b1, 13'h0040);
        chk("arst_nofill_ok", 32'(bus.rom_ok), 32'd0);
        chk("arst_nofill_data", 32'(bus.rom_data), 32'd0);
        step();
        chk("arst_fresh_req", 32'(bus.sdram_req), 32'd1);
        chk("arst_fresh_addr", 32'(bus.sdram_addr), 32'h120);
        serve(13'h0040, 16'hDDDD);
        chk("arst_fill_data", 32'(bus.rom_data), 32'hDD);

        // ack and dst together in REQ
        set_rom(1'b1, 13'h0051);
        step();
        bus.sdram_ack = 1'b1; bus.sdram_dst = 1'b1; bus.sdram_din = 16'h1111;
        step();
        bus.sdram_ack = 1'b0; bus.sdram_dst = 1'b0;
        chk("ackdst_ok0", 32'(bus.rom_ok), 32'd0);
        chk("ackdst_wait", 32'(bus.sdram_req), 32'd0);
        step();
        chk("ackdst_ok1", 32'(bus.rom_ok), 32'd0);
        bus.sdram_din = 16'h2222; bus.sdram_dst = 1'b1;
        step();
        bus.sdram_dst = 1'b0;
        chk("ackdst_fill_ok", 32'(bus.rom_ok), 32'd1);
        chk("ackdst_fill_data", 32'(bus.rom_data), 32'h22);

        // random traffic against the word-cache model
        m_valid = 1'b1; m_tag = 12'h028; m_data = 16'h2222;
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            a = 13'($urandom_range(0, 8191));
            if (r < 4 && m_valid) a = {m_tag, 1'($urandom_range(0, 1))};
            if (r == 9) begin
                bus.inval = 1'b1;
                #1;
                chk("rnd_inval_ok", 32'(bus.rom_ok), 32'd0);
                step();
                bus.inval = 1'b0;
                m_valid = 1'b0;
            end else if (r == 8) begin
                set_rom(1'b0, a);
                chk("rnd_nocs_ok", 32'(bus.rom_ok), 32'd0);
                chk("rnd_nocs_data", 32'(bus.rom_data), 32'(pick(m_data, a)));
                step();
                chk("rnd_nocs_noreq", 32'(bus.sdram_req), 32'd0);
            end else begin
                set_rom(1'b1, a);
                exp_hit = m_valid && (m_tag == a[AW-1:1]);
                chk("rnd_ok", 32'(bus.rom_ok), 32'(exp_hit));
                chk("rnd_data", 32'(bus.rom_data), 32'(pick(m_data, a)));
                if (exp_hit) begin
                    step();
                    chk("rnd_hit_noreq", 32'(bus.sdram_req), 32'd0);
                end else begin
                    din = 16'($urandom);
                    serve(a, din);
                    m_valid = 1'b1; m_tag = a[AW-1:1]; m_data = din;
                    chk("rnd_fill_ok", 32'(bus.rom_ok), 32'd1);
                    chk("rnd_fill_data", 32'(bus.rom_data), 32'(pick(m_data, a)));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/jtkicker_romslot.md
JTKICKER_ROMSLOT -- requirements
Module: jtkicker_romslot

Interface
REQ-001 SHALL have parameter AW, default 13, giving the byte-address width of the ROM request port.
REQ-002 SHALL have parameter [21:0] OFFSET, default 0, giving the SDRAM word offset added to every fetch address.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rom_cs, input, 1 bit: the requester (game CPU/video) wants data at rom_addr.
REQ-006 SHALL have port rom_addr, input, AW bits: the byte address.
REQ-007 SHALL have port rom_data, output, 8 bits: the byte at rom_addr, valid while rom_ok=1.
REQ-008 SHALL have port rom_ok, output, 1 bit: rom_data is valid for the current rom_addr.
REQ-009 SHALL have port inval, input, 1 bit: discards cached data (asserted during ioctl download).
REQ-010 SHALL have port sdram_addr, output, 22 bits: the word address, equal to OFFSET + rom_addr[AW-1:1] (zero-extended), modulo 2^22.
REQ-011 SHALL have port sdram_req, output, 1 bit: fetch request, held until acknowledged.
REQ-012 SHALL have port sdram_ack, input, 1 bit: the controller accepted the request.
REQ-013 SHALL have port sdram_dst, input, 1 bit: a one-cycle strobe marking sdram_din valid.
REQ-014 SHALL have port sdram_din, input, 16 bits: the fetched word; the low byte is the even address.

Function
REQ-015 SHALL hold a one-word cache: a 16-bit data register, an (AW-1)-bit tag register and a valid bit.
REQ-016 SHALL compute hit as valid and (tag == rom_addr[AW-1:1]).
REQ-017 SHALL drive rom_ok = rom_cs and hit, combinationally from the registers: zero latency on a hit.
REQ-018 SHALL drive rom_data from data[7:0] when rom_addr[0]=0 and from data[15:8] when rom_addr[0]=1, regardless of rom_ok.
REQ-019 SHALL implement FSM states IDLE, REQ and WAIT.
REQ-020 SHALL move IDLE->REQ on the clock edge where rom_cs=1 and hit=0, latching the fetch word address into sdram_addr and the tag-pending register.
REQ-021 SHALL assert sdram_req exactly while in REQ, and move REQ->WAIT on the edge where sdram_ack=1.
REQ-022 SHALL, in WAIT on the edge where sdram_dst=1, load data<=sdram_din, tag<=tag-pending and valid<=1, then return to IDLE.
REQ-023 SHALL keep sdram_addr stable from entry into REQ until return to IDLE.
REQ-024 SHALL complete a fetch that has started even if rom_cs drops or rom_addr changes; the fill uses the latched address.
REQ-025 SHALL, after such a fill, re-evaluate hit in IDLE and start a new fetch one cycle later if the current rom_addr still misses.
REQ-026 SHALL ignore sdram_dst outside WAIT and ignore sdram_ack outside REQ.
REQ-027 SHALL, when sdram_ack and sdram_dst arrive in the same cycle in REQ, move to WAIT only; dst is not consumed in that cycle.
REQ-028 SHALL clear valid on any edge where inval=1.
REQ-029 SHALL give inval priority over a simultaneous fill: valid ends at 0, while data and tag still load.
REQ-030 SHALL keep a fetch that is in progress running when inval is asserted.
REQ-031 SHALL start a fetch on a cs miss only while inval=0.
REQ-032 SHALL keep rom_ok at 0 while inval=1.
REQ-033 SHALL NOT produce rom_ok from an address that only matches the pending tag before the fill edge.

Reset
REQ-034 SHALL, while rst_n=0, force state=IDLE, valid=0, sdram_req=0, sdram_addr=OFFSET, data=0 and tag=0, giving rom_ok=0 and rom_data=0.
REQ-035 SHALL make the reset take effect immediately (asynchronous) even mid-fetch, and discard any later dst from the aborted fetch.
REQ-036 SHALL resume operation on the first clock edge after rst_n rises.

Verification
REQ-037 SHALL pass a cold miss: OFFSET=22'h100, rom_addr=13'h0005, rom_cs=1 -> sdram_req=1 next cycle with sdram_addr=22'h102; ack on cycle 3; dst on cycle 6 with din=16'hBEEF -> rom_ok=1 and rom_data=8'hBE after edge 6.
REQ-038 SHALL pass a hit: after REQ-037, rom_addr=13'h0004 -> rom_ok=1 in the same cycle, rom_data=8'hEF, sdram_req stays 0.
REQ-039 SHALL pass an address change mid-fetch: miss on 13'h0010, then rom_addr=13'h0020 during WAIT -> fill of tag 8, rom_ok stays 0, and a second request with sdram_addr=OFFSET+16 one cycle after the fill.
REQ-040 SHALL pass inval coincident with dst: valid stays 0, rom_ok=0, and with rom_cs held and inval dropped a new fetch of the same address starts.
REQ-041 SHALL pass reset in WAIT: rst_n low then high, stale dst pulse -> valid=0, no fill, and the FSM starts a fresh request on the next rom_cs.
REQ-042 SHALL pass ack and dst in the same cycle in REQ: the FSM enters WAIT and only the next dst fills the cache.
